// File: rtl/riscv_writeback_pkg.sv
// Shared definitions for the RISC-V writeback stage: select codes, load
// encodings and default sizing.
package riscv_writeback_pkg;

    localparam int unsigned DATA_WIDTH_DEF   = 32;
    localparam int unsigned STARVE_LIMIT_DEF = 4;
    localparam int unsigned REG_ADDR_W       = 5;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_NONE = 2'b11
    } wb_sel_e;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;

    // True for the five load widths the stage knows how to format.
    function automatic logic load_f3_legal(input logic [2:0] f3);
        return (f3 == F3_LB)  || (f3 == F3_LH)  || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/riscv_wb_fifo.sv
// Two-entry queue holding long-latency results until the write port is free.
module riscv_wb_fifo #(
    parameter int unsigned WIDTH = 37
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_c,
    output logic [1:0]       count,
    output logic             not_full
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push_c;
    logic             do_pop_c;
    logic [1:0]       count_next_c;

    // A full queue refuses pushes even when it is popped in the same cycle.
    assign do_push_c = push && (count != 2'd2);
    assign do_pop_c  = pop && (count != 2'd0);
    assign head_c    = mem[rd_ptr];

    always_comb begin
        count_next_c = count;
        if (do_push_c && !do_pop_c) begin
            count_next_c = count + 2'd1;
        end else if (!do_push_c && do_pop_c) begin
            count_next_c = count - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            not_full <= 1'b1;
        end else begin
            if (do_push_c) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop_c) begin
                rd_ptr <= ~rd_ptr;
            end
            count    <= count_next_c;
            not_full <= (count_next_c != 2'd2);
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/riscv_writeback.sv
// Writeback stage: arbitrates the single register-file write port between the
// in-order pipeline and a queued long-latency unit, and formats load data.
module riscv_writeback
    import riscv_writeback_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p_valid,
    input  logic [REG_ADDR_W-1:0] p_rd,
    input  logic [1:0]            p_wb_sel,
    input  logic [DATA_WIDTH-1:0] p_alu,
    input  logic [DATA_WIDTH-1:0] p_pc4,
    input  logic [DATA_WIDTH-1:0] p_ld_data,
    input  logic [2:0]            p_funct3,
    input  logic [1:0]            p_addr_lo,
    output logic                  p_stall,
    input  logic                  l_valid,
    output logic                  l_ready,
    input  logic [REG_ADDR_W-1:0] l_rd,
    input  logic [DATA_WIDTH-1:0] l_data,
    output logic                  reg_wen,
    output logic [REG_ADDR_W-1:0] addr_d,
    output logic [DATA_WIDTH-1:0] data_d,
    output logic                  ld_err
);

    localparam int unsigned ENTRY_W  = REG_ADDR_W + DATA_WIDTH;
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic                  p_grant_c;
    logic                  l_grant_c;
    logic                  l_push_c;
    logic [ENTRY_W-1:0]    fifo_head_c;
    logic [1:0]            fifo_count;
    logic                  fifo_not_full;
    logic [REG_ADDR_W-1:0] head_rd_c;
    logic [DATA_WIDTH-1:0] head_data_c;
    logic [7:0]            ld_byte_c;
    logic [15:0]           ld_half_c;
    logic [DATA_WIDTH-1:0] ld_fmt_c;
    logic [DATA_WIDTH-1:0] p_data_c;
    logic                  ld_err_c;
    logic [STARVE_W-1:0]   starve_cnt;
    logic [STARVE_W-1:0]   starve_next_c;

    // Pipeline wins the port unless a forced stall hands it to the queue.
    assign p_grant_c = p_valid && !p_stall;
    assign l_grant_c = !p_grant_c && (fifo_count != 2'd0);
    assign l_push_c  = l_valid && l_ready;
    assign l_ready   = fifo_not_full;
    assign {head_rd_c, head_data_c} = fifo_head_c;

    riscv_wb_fifo #(
        .WIDTH(ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (l_push_c),
        .push_data({l_rd, l_data}),
        .pop      (l_grant_c),
        .head_c   (fifo_head_c),
        .count    (fifo_count),
        .not_full (fifo_not_full)
    );

    // Load alignment and extension.
    always_comb begin
        ld_byte_c = p_ld_data[{p_addr_lo, 3'b000} +: 8];
        ld_half_c = p_ld_data[{p_addr_lo[1], 4'b0000} +: 16];
        ld_fmt_c  = '0;
        case (p_funct3)
            F3_LB:   ld_fmt_c = DATA_WIDTH'($signed(ld_byte_c));
            F3_LH:   ld_fmt_c = DATA_WIDTH'($signed(ld_half_c));
            F3_LW:   ld_fmt_c = p_ld_data;
            F3_LBU:  ld_fmt_c = DATA_WIDTH'(ld_byte_c);
            F3_LHU:  ld_fmt_c = DATA_WIDTH'(ld_half_c);
            default: ld_fmt_c = '0;
        endcase
    end

    always_comb begin
        p_data_c = '0;
        ld_err_c = 1'b0;
        case (p_wb_sel)
            WB_ALU:  p_data_c = p_alu;
            WB_LOAD: begin
                p_data_c = ld_fmt_c;
                ld_err_c = !load_f3_legal(p_funct3);
            end
            WB_PC4:  p_data_c = p_pc4;
            default: p_data_c = '0;
        endcase
    end

    // Counts cycles the queue head is bypassed by the pipeline.
    always_comb begin
        starve_next_c = '0;
        if ((fifo_count != 2'd0) && p_grant_c) begin
            starve_next_c = starve_cnt + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_wen    <= 1'b0;
            addr_d     <= '0;
            data_d     <= '0;
            ld_err     <= 1'b0;
            p_stall    <= 1'b0;
            starve_cnt <= '0;
        end else begin
            reg_wen <= 1'b0;
            addr_d  <= '0;
            data_d  <= '0;
            ld_err  <= 1'b0;
            if (p_grant_c) begin
                reg_wen <= (p_rd != '0) && (p_wb_sel != WB_NONE);
                addr_d  <= p_rd;
                data_d  <= p_data_c;
                ld_err  <= ld_err_c;
            end else if (l_grant_c) begin
                reg_wen <= (head_rd_c != '0);
                addr_d  <= head_rd_c;
                data_d  <= head_data_c;
            end
            starve_cnt <= starve_next_c;
            p_stall    <= (starve_next_c == STARVE_W'(STARVE_LIMIT));
        end
    end

endmodule

// File: doc/riscv_writeback.md
RISCV_WRITEBACK -- requirements
Module: riscv_writeback

Interface
REQ-001 Parameter DATA_WIDTH, default 32: register data width.
REQ-002 Parameter STARVE_LIMIT, default 4: cycles a queued long-latency result waits before pipeline stall is forced.
REQ-003 Ports (clk, reset first):
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- p_valid  in  1  pipeline result valid this cycle.
- p_rd  in  5  destination register.
- p_wb_sel  in  2  00 ALU, 01 load, 10 PC+4, 11 none.
- p_alu  in  32  ALU result.
- p_pc4  in  32  PC+4.
- p_ld_data  in  32  raw data-memory word.
- p_funct3  in  3  load type.
- p_addr_lo  in  2  load byte offset.
- p_stall  out  1  pipeline must not assert p_valid next cycle.
- l_valid  in  1  long-latency result offered.
- l_ready  out  1  long-latency result accepted when l_valid && l_ready.
- l_rd  in  5  long-latency destination.
- l_data  in  32  long-latency data.
- reg_wen  out  1  register-file write enable.
- addr_d  out  5  write address.
- data_d  out  32  write data.
- ld_err  out  1  one-cycle pulse: illegal load funct3.
REQ-004 Clock is clk; reset is synchronous and active-high, named reset.

Function
REQ-005 Write port single; each cycle at most one grant: P if p_valid, else FIFO head if non-empty.
REQ-006 Granted result registered; reg_wen/addr_d/data_d valid exactly 1 cycle after grant.
REQ-007 Grant with rd==0 or p_wb_sel==11 SHALL produce reg_wen=0; FIFO entry still popped.
REQ-008 Load format (p_wb_sel==01): LB 000 sign-extend byte[addr_lo]; LH 001 sign-extend half[addr_lo[1]]; LW 010 full word, addr_lo ignored; LBU 100/LHU 101 zero-extend.
REQ-009 funct3 011/110/111 with load: data_d=0, reg_wen follows REQ-007, ld_err pulses with reg_wen cycle.
REQ-010 L side: 2-entry FIFO; l_ready = (count<2), from registered count only; no enqueue when full even if dequeue same cycle.
REQ-011 Simultaneous P grant and L enqueue: both occur; FIFO drained in arrival order.
REQ-012 Starvation counter: increments each cycle FIFO non-empty and P granted; clears on FIFO pop or empty.
REQ-013 Counter reaching STARVE_LIMIT SHALL assert p_stall for next cycle exactly one cycle; that cycle FIFO head granted; p_valid asserted during p_stall is ignored (not written).
REQ-014 Write ordering equals grant order; same-rd ordering between P and L is upstream responsibility.

Reset
REQ-015 In a reset cycle: reg_wen=0, addr_d=0, data_d=0, ld_err=0, p_stall=0, FIFO count=0, counter=0; l_ready=1 first cycle after reset.
REQ-016 Reset mid-operation discards queued and in-flight results; no write occurs in cycle after reset.

Structure
REQ-017 Shared package holds wb_sel codes, load funct3 codes, DATA_WIDTH and STARVE_LIMIT defaults.
REQ-018 Sub-module riscv_wb_fifo (2-entry, count, push/pop) SHALL hold the L queue; load formatting stays inline.

Verification
REQ-019 LB, p_ld_data=0x1234_80FF, addr_lo=1, rd=5 -> next cycle reg_wen=1, addr_d=5, data_d=0xFFFF_FF80.
REQ-020 LHU same word, addr_lo=2 -> data_d=0x0000_1234; funct3=011 -> data_d=0, ld_err=1.
REQ-021 p_valid rd=0 ALU 0xDEAD -> reg_wen stays 0.
REQ-022 Two L pushes with p_valid held high -> l_ready=0 after 2nd; 4 cycles later p_stall=1 one cycle; then first L entry written.
REQ-023 P and L same cycle, FIFO empty -> P written cycle+1, L written cycle+2 (p_valid low).
REQ-024 Reset asserted with 2 entries queued -> all outputs 0 next cycle, l_ready=1, no L write afterwards.
